// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg
//   Shared AXI4-Lite constants and the initiator state type.
//   RESP_* : the four AXI response encodings.
//   master_state_t : state encoding for axi_lite_master_if.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } master_state_t;

endpackage

// File: rtl/axi_lite_master_if.sv
// axi_lite_master_if
//   Single-outstanding AXI4-Lite initiator: converts a cmd/rsp handshake
//   into one-beat AXI4-Lite writes or reads.
// Ports
//   m_axi_aclk, reset           clock, synchronous active-high reset
//   cmd_*                       command in (valid/ready, write, addr, wdata, wstrb)
//   rsp_*                       response out (valid/ready, rdata, resp)
//   m_axi_aw*/w*/b*/ar*/r*      AXI4-Lite initiator channels
//   err_count, err_clear        only with AXI_LITE_MASTER_ERR_CNT_EN defined:
//                               saturating count of non-OKAY responses
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | cmd_ready high, waiting for a command
// WR_REQ  | AW and W offered; each drops after its handshake
// WR_RESP | bready high, waiting for bvalid
// RD_REQ  | arvalid high, waiting for arready
// RD_DATA | rready high, waiting for rvalid
// RSP     | rsp_valid high, waiting for rsp_ready
module axi_lite_master_if
  import axi_lite_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32
) (
  input  logic                          m_axi_aclk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]                   cmd_wdata,
  input  logic [3:0]                    cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [31:0]                   rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          m_axi_awvalid,
  input  logic                          m_axi_awready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]                    m_axi_awprot,
  output logic                          m_axi_wvalid,
  input  logic                          m_axi_wready,
  output logic [31:0]                   m_axi_wdata,
  output logic [3:0]                    m_axi_wstrb,
  input  logic                          m_axi_bvalid,
  output logic                          m_axi_bready,
  input  logic [1:0]                    m_axi_bresp,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                    m_axi_arprot,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready,
  input  logic [31:0]                   m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp
`ifdef AXI_LITE_MASTER_ERR_CNT_EN
  ,
  output logic [15:0]                   err_count,
  input  logic                          err_clear
`endif
);

  master_state_t                 state;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [31:0]                   wdata_q;
  logic [3:0]                    wstrb_q;
  logic                          aw_done;
  logic                          w_done;
  logic [31:0]                   rdata_q;
  logic [1:0]                    resp_q;
  logic                          aw_hs;
  logic                          w_hs;

  // Gated with reset so no ready is advertised while reset is held.
  assign cmd_ready     = (state == IDLE) && !reset;
  assign rsp_valid     = (state == RSP);
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;

  assign m_axi_awvalid = (state == WR_REQ) && !aw_done;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wvalid  = (state == WR_REQ) && !w_done;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_bready  = (state == WR_RESP);
  assign m_axi_arvalid = (state == RD_REQ);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_rready  = (state == RD_DATA);

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;

  always_ff @(posedge m_axi_aclk) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      rdata_q <= '0;
      resp_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            state   <= cmd_write ? WR_REQ : RD_REQ;
          end
        end
        WR_REQ: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          // Leave in the cycle the later of the two handshakes completes.
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            resp_q  <= m_axi_bresp;
            rdata_q <= '0;
            state   <= RSP;
          end
        end
        RD_REQ: begin
          if (m_axi_arready) state <= RD_DATA;
        end
        RD_DATA: begin
          if (m_axi_rvalid) begin
            resp_q  <= m_axi_rresp;
            rdata_q <= m_axi_rdata;
            state   <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXI_LITE_MASTER_ERR_CNT_EN
  logic err_event;

  assign err_event = ((state == WR_RESP) && m_axi_bvalid && (m_axi_bresp != RESP_OKAY)) ||
                     ((state == RD_DATA) && m_axi_rvalid && (m_axi_rresp != RESP_OKAY));

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_ff @(posedge m_axi_aclk) begin
    if (reset || err_clear) begin
      err_count <= '0;
    end else if (err_event && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule
